present_mode_ctrl: RTL and testbench

//  Block-cipher mode controller placed directly upstream of present_core. Accepts a stream of
//  64-bit blocks on a valid/ready input and applies ECB or CBC chaining (encrypt or decrypt).

---
 rtl/present_mode_ctrl.sv | 160 ++++++++++++++++
 tb/tb_present_mode_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/present_mode_ctrl.sv
// -----------------------------------------------------------------------------
// present_mode_ctrl
//   Block-cipher mode controller that sits directly in front of present_core.
//   It accepts 64-bit blocks on a valid/ready stream and applies ECB or CBC
//   chaining, in either the encrypt or the decrypt direction. For each block it
//   drives the core (load/control/idat/key) and waits for core_done. The result
//   is then presented on a valid/ready output stream. Only one block is in
//   flight at a time. A watchdog drops a block and raises a sticky error if the
//   core never answers.
//
// Parameters
//   TIMEOUT  maximum number of WAIT cycles before a block is abandoned (>=2)
//   CNT_W    watchdog counter width, 2**CNT_W >= TIMEOUT
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   cfg_key/iv/mode/dir        configuration, latched on cfg_start (IDLE only)
//   cfg_start                  1-cycle pulse: latch config, reload IV, clear error
//   s_valid/s_ready/s_data/s_last   input block stream
//   m_valid/m_ready/m_data/m_last   output block stream
//   core_idat/key/load/control      towards present_core
//   core_odat/core_done             from present_core
//   busy                       controller is not IDLE
//   err_timeout                sticky watchdog error
// -----------------------------------------------------------------------------
module present_mode_ctrl #(
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [79:0] cfg_key,
  input  logic [63:0] cfg_iv,
  input  logic        cfg_mode,
  input  logic        cfg_dir,
  input  logic        cfg_start,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [63:0] s_data,
  input  logic        s_last,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [63:0] m_data,
  output logic        m_last,
  output logic [63:0] core_idat,
  output logic [79:0] core_key,
  output logic        core_load,
  output logic        core_control,
  input  logic [63:0] core_odat,
  input  logic        core_done,
  output logic        busy,
  output logic        err_timeout
);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, OUT} state_t;

  state_t           state;
  logic [63:0]      chain;
  logic [63:0]      iv_r;
  logic [63:0]      blk;
  logic [79:0]      key_r;
  logic             mode_r;
  logic             dir_r;
  logic             last_r;
  logic [CNT_W-1:0] counter;
  logic [63:0]      result;
  logic             timeout_hit;

  // cfg_start has priority over a new block, so the input is not ready in that cycle.
  assign s_ready = (state == IDLE) && !cfg_start;
  assign busy    = (state != IDLE);

  assign timeout_hit = (counter == CNT_W'(TIMEOUT - 1));

  // Only a CBC decrypt unwinds the chaining on the output side.
  // NOTE: every signal driven in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    result = core_odat;
    if (mode_r && dir_r) result = core_odat ^ chain;
  end

  // NOTE: synchronous reset and non-blocking assignments throughout; all state is reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      chain        <= '0;
      iv_r         <= '0;
      blk          <= '0;
      key_r        <= '0;
      mode_r       <= 1'b0;
      dir_r        <= 1'b0;
      last_r       <= 1'b0;
      counter      <= '0;
      m_valid      <= 1'b0;
      m_data       <= '0;
      m_last       <= 1'b0;
      core_idat    <= '0;
      core_key     <= '0;
      core_load    <= 1'b0;
      core_control <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_start) begin
            key_r       <= cfg_key;
            iv_r        <= cfg_iv;
            chain       <= cfg_iv;
            mode_r      <= cfg_mode;
            dir_r       <= cfg_dir;
            err_timeout <= 1'b0;
          end else if (s_valid) begin
            blk          <= s_data;
            last_r       <= s_last;
            // The core registers are set up here so that they are already
            // valid while the FSM sits in LOAD. They then stay put until the next block.
            core_load    <= 1'b1;
            core_control <= dir_r;
            core_key     <= key_r;
            core_idat    <= (mode_r && !dir_r) ? (s_data ^ chain) : s_data;
            state        <= LOAD;
          end
        end

        LOAD: begin
          core_load <= 1'b0;
          counter   <= '0;
          state     <= WAIT;
        end

        WAIT: begin
          if (core_done) begin
            if (mode_r) chain <= dir_r ? blk : core_odat;
            m_data  <= result;
            m_last  <= last_r;
            m_valid <= 1'b1;
            state   <= OUT;
          end else if (timeout_hit) begin
            err_timeout <= 1'b1;
            state       <= IDLE;
          end else begin
            counter <= counter + 1'b1;
          end
        end

        OUT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            // End of message: the next block starts again from the configured IV.
            if (m_last) chain <= iv_r;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_present_mode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_present_mode_ctrl
//   Bench for present_mode_ctrl. A behavioural PRESENT-80 core model answers
//   each core_load after a fixed latency. The stimulus process pushes the
//   expected output blocks into a queue. A separate monitor pops that queue and
//   compares against every output transfer.
// -----------------------------------------------------------------------------
module tb_present_mode_ctrl;

  localparam int TIMEOUT  = 16;
  localparam int CNT_W    = 5;
  localparam int CORE_LAT = 5;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [79:0] KONE = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] E0   = 64'h5579_C138_7B22_8445;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [79:0] cfg_key = '0;
  logic [63:0] cfg_iv = '0;
  logic        cfg_mode = 1'b0;
  logic        cfg_dir = 1'b0;
  logic        cfg_start = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [63:0] s_data = '0;
  logic        s_last = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [63:0] m_data;
  logic        m_last;
  logic [63:0] core_idat;
  logic [79:0] core_key;
  logic        core_load;
  logic        core_control;
  logic [63:0] core_odat;
  logic        core_done;
  logic        busy;
  logic        err_timeout;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } exp_t;
  exp_t exp_q[$];

  present_mode_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .cfg_key(cfg_key), .cfg_iv(cfg_iv), .cfg_mode(cfg_mode), .cfg_dir(cfg_dir),
    .cfg_start(cfg_start),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .core_idat(core_idat), .core_key(core_key), .core_load(core_load),
    .core_control(core_control), .core_odat(core_odat), .core_done(core_done),
    .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // ---------------- PRESENT-80 reference ----------------
  function automatic logic [3:0] sb(input logic [3:0] x);
    case (x)
      4'h0: sb = 4'hC; 4'h1: sb = 4'h5; 4'h2: sb = 4'h6; 4'h3: sb = 4'hB;
      4'h4: sb = 4'h9; 4'h5: sb = 4'h0; 4'h6: sb = 4'hA; 4'h7: sb = 4'hD;
      4'h8: sb = 4'h3; 4'h9: sb = 4'hE; 4'hA: sb = 4'hF; 4'hB: sb = 4'h8;
      4'hC: sb = 4'h4; 4'hD: sb = 4'h7; 4'hE: sb = 4'h1; default: sb = 4'h2;
    endcase
  endfunction

  function automatic logic [3:0] sbi(input logic [3:0] x);
    sbi = 4'h0;
    for (int j = 0; j < 16; j++) if (sb(4'(j)) == x) sbi = 4'(j);
  endfunction

  function automatic logic [63:0] s_layer(input logic [63:0] s, input bit inv);
    s_layer = '0;
    for (int i = 0; i < 16; i++) s_layer[4*i +: 4] = inv ? sbi(s[4*i +: 4]) : sb(s[4*i +: 4]);
  endfunction

  function automatic logic [63:0] p_layer(input logic [63:0] s, input bit inv);
    int p;
    p_layer = '0;
    for (int i = 0; i < 64; i++) begin
      p = (i == 63) ? 63 : (i * 16) % 63;
      if (inv) p_layer[i] = s[p];
      else     p_layer[p] = s[i];
    end
  endfunction

  function automatic logic [63:0] present(input logic [63:0] d, input logic [79:0] k, input bit dec);
    logic [63:0] rk [1:32];
    logic [79:0] kr;
    logic [63:0] s;
    kr = k;
    for (int i = 1; i <= 32; i++) begin
      rk[i] = kr[79:16];
      kr = {kr[18:0], kr[79:19]};
      kr[79:76] = sb(kr[79:76]);
      kr[19:15] = kr[19:15] ^ 5'(i);
    end
    if (!dec) begin
      s = d;
      for (int i = 1; i <= 31; i++) s = p_layer(s_layer(s ^ rk[i], 1'b0), 1'b0);
      s = s ^ rk[32];
    end else begin
      s = d ^ rk[32];
      for (int i = 31; i >= 1; i--) s = s_layer(p_layer(s, 1'b1), 1'b1) ^ rk[i];
    end
    return s;
  endfunction

  // ---------------- core model ----------------
  bit          core_dead = 1'b0;
  int          core_cnt;
  logic [63:0] core_res;

  always @(posedge clk) begin
    if (reset) begin
      core_cnt  <= 0;
      core_done <= 1'b0;
      core_odat <= '0;
      core_res  <= '0;
    end else begin
      core_done <= 1'b0;
      if (core_load) begin
        core_cnt <= CORE_LAT;
        core_res <= present(core_idat, core_key, core_control);
      end else if (core_cnt != 0) begin
        core_cnt <= core_cnt - 1;
        if (core_cnt == 1 && !core_dead) begin
          core_done <= 1'b1;
          core_odat <= core_res;
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one comparison per output transfer.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h expected none", m_data);
      end else begin
        e = exp_q.pop_front();
        check("m_data", 80'(m_data), 80'(e.data));
        check("m_last", 80'(m_last), 80'(e.last));
      end
    end
  end

  // ---------------- stimulus helpers (start and end at posedge+1) ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [79:0] k, input logic [63:0] iv, input logic mode, input logic dir);
    cfg_key = k; cfg_iv = iv; cfg_mode = mode; cfg_dir = dir; cfg_start = 1'b1;
    #1;
    check("s_ready_during_cfg_start", 80'(s_ready), 80'(0));
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic send(input logic [63:0] d, input logic l, input bit push, input logic [63:0] ed);
    bit got = 1'b0;
    int n = 0;
    if (push) exp_q.push_back('{data: ed, last: l});
    s_valid = 1'b1; s_data = d; s_last = l;
    while (!got && n < 200) begin
      @(negedge clk);
      got = s_ready;
      tick();
      n++;
    end
    s_valid = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no s_ready expected s_ready within 200 cycles");
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || m_valid) && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy expected idle within 500 cycles");
    end
    check("queue_drained", 80'(exp_q.size()), 80'(0));
  endtask

  // ---------------- main sequence ----------------
  logic [63:0] e_e0;

  initial begin
    e_e0 = present(E0, 80'h0, 1'b0);
    repeat (3) tick();
    reset = 1'b0;
    #1;
    check("rst_s_ready", 80'(s_ready), 80'(1));
    check("rst_busy", 80'(busy), 80'(0));
    check("rst_m_valid", 80'(m_valid), 80'(0));
    check("rst_core_load", 80'(core_load), 80'(0));
    check("rst_err", 80'(err_timeout), 80'(0));
    tick();

    // 1: ECB encrypt, two known-answer vectors
    cfg(80'h0, 64'h0, 1'b0, 1'b0);
    send(64'h0, 1'b0, 1'b1, E0);
    wait_idle();
    cfg(KONE, 64'h0, 1'b0, 1'b0);
    send(ONES, 1'b1, 1'b1, 64'h3333_DCD3_2132_10D2);
    wait_idle();

    // 2: ECB decrypt, single-cycle core_load with control=1
    cfg(80'h0, 64'h0, 1'b0, 1'b1);
    send(E0, 1'b0, 1'b1, 64'h0);
    check("load_pulse_hi", 80'(core_load), 80'(1));
    check("load_control", 80'(core_control), 80'(1));
    check("load_idat", 80'(core_idat), 80'(E0));
    tick();
    check("load_pulse_lo", 80'(core_load), 80'(0));
    wait_idle();

    // 3: CBC encrypt, then CBC decrypt of the ciphertext
    cfg(80'h0, ONES, 1'b1, 1'b0);
    send(ONES, 1'b0, 1'b1, E0);
    check("cbc_core_idat", 80'(core_idat), 80'(0));
    send(64'h0, 1'b1, 1'b1, e_e0);
    wait_idle();
    cfg(80'h0, ONES, 1'b1, 1'b1);
    send(E0, 1'b0, 1'b1, ONES);
    send(e_e0, 1'b1, 1'b1, 64'h0);
    wait_idle();

    // 4: re-IV after a last block, no cfg_start in between
    cfg(80'h0, ONES, 1'b1, 1'b0);
    send(ONES, 1'b1, 1'b1, E0);
    send(ONES, 1'b1, 1'b1, E0);
    wait_idle();

    // 5: watchdog timeout
    cfg(80'h0, 64'h0, 1'b0, 1'b0);
    core_dead = 1'b1;
    send(64'h0, 1'b0, 1'b0, 64'h0);
    repeat (TIMEOUT) tick();
    check("to_err_before", 80'(err_timeout), 80'(0));
    check("to_busy_before", 80'(busy), 80'(1));
    tick();
    check("to_err_after", 80'(err_timeout), 80'(1));
    check("to_busy_after", 80'(busy), 80'(0));
    check("to_no_m_valid", 80'(m_valid), 80'(0));
    core_dead = 1'b0;
    tick();
    send(64'h0, 1'b0, 1'b1, E0);
    wait_idle();
    check("to_err_sticky", 80'(err_timeout), 80'(1));
    cfg(80'h0, 64'h0, 1'b0, 1'b0);
    check("to_err_cleared", 80'(err_timeout), 80'(0));

    // 6: output backpressure, then reset mid-WAIT
    m_ready = 1'b0;
    send(64'h0, 1'b0, 1'b1, E0);
    begin
      int n = 0;
      while (!m_valid && n < 100) begin
        tick();
        n++;
      end
      check("bp_m_valid_seen", 80'(m_valid), 80'(1));
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      check("bp_m_data_stable", 80'(m_data), 80'(E0));
      check("bp_s_ready_low", 80'(s_ready), 80'(0));
    end
    m_ready = 1'b1;
    wait_idle();

    send(64'h0, 1'b0, 1'b0, 64'h0);
    repeat (3) tick();
    check("mid_wait_busy", 80'(busy), 80'(1));
    reset = 1'b1;
    tick();
    check("rst2_m_valid", 80'(m_valid), 80'(0));
    check("rst2_m_data", 80'(m_data), 80'(0));
    check("rst2_core_idat", 80'(core_idat), 80'(0));
    check("rst2_core_key", 80'(core_key), 80'(0));
    check("rst2_core_load", 80'(core_load), 80'(0));
    check("rst2_busy", 80'(busy), 80'(0));
    check("rst2_s_ready", 80'(s_ready), 80'(1));
    check("rst2_err", 80'(err_timeout), 80'(0));
    reset = 1'b0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
